// File: rtl/buscador_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Holds the FSM encoding, the flag sanity check and the default sizing.
package buscador_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_CMP_LAT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A trustworthy comparator answer raises exactly one of E/G/L.
    function automatic logic es_one_hot(input logic e, input logic g, input logic l);
        return ({e, g, l} == 3'b100) || ({e, g, l} == 3'b010) || ({e, g, l} == 3'b001);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Settling-time counter: counts up from a load until it reaches CMP_LAT,
// then holds and raises tc so the search knows the comparator flags are valid.
module contador_espera #(
    parameter int CMP_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (CMP_LAT < 1) ? 1 : $clog2(CMP_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CW'(CMP_LAT));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buscador_sar.sv
// Successive-approximation search: drives the comparator a-side with trial
// values and narrows bit by bit (MSB first) toward the unknown b-side target.
module buscador_sar
    import buscador_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cmp_e,
    input  logic                     cmp_g,
    input  logic                     cmp_l,
    output logic [WIDTH-1:0]         guess,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(WIDTH):0]   steps
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] work;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             err_q, err_d;
    logic             tc;

    // With a combinational comparator every PROBE cycle is a sample cycle.
    generate
        if (CMP_LAT == 0) begin : g_sin_espera
            assign tc = 1'b1;
        end else begin : g_espera
            logic load;
            assign load = ((state_q == ST_IDLE) && start) || ((state_q == ST_PROBE) && tc);
            contador_espera #(.CMP_LAT(CMP_LAT)) u_espera (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load),
                .en    (state_q == ST_PROBE),
                .tc    (tc)
            );
        end
    endgenerate

    // A "greater" answer means the trial bit overshoots the target and is dropped.
    assign work = cmp_g ? (guess_q & ~(WIDTH'(1) << k_q)) : guess_q;

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        k_d      = k_q;
        steps_d  = steps_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PROBE;
                    guess_d = WIDTH'(1) << (WIDTH - 1);
                    k_d     = KW'(WIDTH - 1);
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_PROBE: begin
                if (tc) begin
                    steps_d = steps_q + SW'(1);
                    if (!es_one_hot(cmp_e, cmp_g, cmp_l)) begin
                        err_d    = 1'b1;
                        result_d = guess_q;
                        state_d  = ST_DONE;
                    end else if (cmp_e) begin
                        result_d = guess_q;
                        state_d  = ST_DONE;
                    end else if (k_q == '0) begin
                        result_d = work;
                        state_d  = ST_DONE;
                    end else begin
                        k_d     = k_q - KW'(1);
                        guess_d = work | (WIDTH'(1) << (k_q - KW'(1)));
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            k_q      <= k_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_PROBE: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign err    = err_q;
    assign steps  = steps_q;

endmodule
